instruction_memory_sync: RTL and testbench
==========================================

Name: instruction_memory_sync

Overview:
- Parametrised, registered instruction memory for the pipelined MIPS core; replaces the fixed combinational ROM in the IF stage.
- Synchronous read with 1-cycle latency and stall hold; fetch addresses are byte addresses relative to a programmable base (e.g. 0x00400000 MARS layout or 0x0).
- Writable loader port for loading programs at runtime (e.g. from a UART boot loader).
- After reset, a clear sequencer zeroes the whole array (NOP-filled) before fetches are accepted.

Parameters:
- ADDR_WIDTH, 8, word-index bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width in bits.
- BASE_ADDR, 32'h00000000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- fetch_addr  input  32  byte address from the PC.
- fetch_req  input  1  fetch request.
- stall  input  1  pipeline stall; holds all fetch outputs.
- instr  output  DATA_WIDTH  fetched instruction.
- instr_valid  output  1  instr corresponds to an accepted request.
- addr_fault  output  1  the accepted request was misaligned or out of range.
- load_we  input  1  loader write strobe.
- load_addr  input  ADDR_WIDTH  loader word index.
- load_data  input  DATA_WIDTH  loader write data.
- ready  output  1  clear sequence done; fetches and loads are accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state<=CLEAR, clr_cnt<=0.
  - instr<=0, instr_valid<=0, addr_fault<=0, ready<=0.
  - Applies mid-operation too; memory contents are re-cleared.
- State CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt++.
  - After the write of index DEPTH-1: state<=RUN, ready<=1. CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - fetch_req and load_we are ignored; instr_valid stays 0.
- State RUN, fetch:
  - offset = fetch_addr - BASE_ADDR, 32-bit with wrap, so addresses below BASE become huge and fault.
  - Fault if offset[1:0]!=0 or offset >= DEPTH*4.
  - Accepted when fetch_req==1 and stall==0. Next cycle: instr_valid<=1.
    - No fault: instr<=mem[offset>>2], addr_fault<=0.
    - Fault: instr<=0 (NOP), addr_fault<=1.
  - stall==1: instr, instr_valid and addr_fault hold their values; the request is not accepted, and the requester re-presents it.
  - fetch_req==0 and stall==0: instr_valid<=0, addr_fault<=0, instr holds.
  - Latency is exactly 1 cycle from acceptance.
- State RUN, load:
  - load_we==1 writes mem[load_addr]<=load_data at the edge. load_addr is always in range.
  - Load and fetch can both happen in the same cycle. If both target the same index, the fetch returns load_data (write-first).
  - load_we is accepted regardless of stall.
- The only transition out of RUN is reset.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit: written as ^data on load, and as 0 during CLEAR.
  - New output parity_err (1 bit, reset 0). It updates with instr on acceptance: 1 if the stored parity mismatches the read word, 0 on fault or when no request is accepted. It holds under stall.
  - Port DBG_PAR_FLIP-free: the bench corrupts parity by hierarchical force on the parity array.
- Not defined:
  - No parity storage and no parity_err port.

Test Plan:
- Reset, then hold reset=1 with ADDR_WIDTH=8 -> ready rises exactly 256 cycles after reset deasserts; a fetch at 0x0 returns instr=0, instr_valid=1, addr_fault=0.
- Load index 3 with 32'h3c044000, then fetch_addr=0x0C with fetch_req=1 -> the next cycle has instr=32'h3c044000, instr_valid=1.
- BASE_ADDR=32'h00400000: fetch 0x0040000C -> word 3. Fetch 0x003FFFFC, 0x00400400 or 0x00400002 -> instr=0, addr_fault=1, instr_valid=1.
- Stall held 3 cycles after a fetch of word 3 while fetch_addr changes to 0x10 -> instr stays 32'h3c044000 and instr_valid stays 1. After release, word 4 appears 1 cycle later.
- Same-cycle load of index 5 with 32'h08100003 and fetch 0x14 -> instr=32'h08100003. Reset asserted mid-run -> ready=0, and after the clear completes word 5 reads 0.
- IMEM_PARITY_EN: load word 7, force its parity bit flipped, fetch 0x1C -> parity_err=1. Fetching an unflipped word -> parity_err=0.

Source files
------------

// File: rtl/instruction_memory_sync.sv
// Registered instruction memory: synchronous 1-cycle fetch with stall hold, runtime loader port,
// post-reset clear sequencer. Optional macro IMEM_PARITY_EN adds per-word even parity and parity_err.
module instruction_memory_sync #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_req,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  addr_fault,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ready
`ifdef IMEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic                  par_mem [DEPTH];
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic                  perr_q, perr_d;

    logic [31:0]           offset;
    logic                  fetch_fault;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  clr_en;
    logic                  load_en;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_perr;

    // Subtraction wraps, so addresses below the base land far out of range and fault.
    assign offset      = fetch_addr - BASE_ADDR;
    assign fetch_fault = (offset[1:0] != 2'b00) || (offset[31:ADDR_WIDTH+2] != '0);
    assign fetch_idx   = offset[ADDR_WIDTH+1:2];

    assign clr_en  = reset && (state_q == S_CLEAR);
    assign load_en = reset && (state_q == S_RUN) && load_we;
    assign bypass  = load_en && (load_addr == fetch_idx);
    assign rd_data = bypass ? load_data : mem[fetch_idx];

`ifdef IMEM_PARITY_EN
    logic rd_par;
    assign rd_par  = bypass ? ^load_data : par_mem[fetch_idx];
    assign rd_perr = (^rd_data) != rd_par;
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_cnt_q] <= '0;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr_en) begin
            par_mem[clr_cnt_q] <= 1'b0;
        end else if (load_en) begin
            par_mem[load_addr] <= ^load_data;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        perr_d    = perr_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                // A stall freezes every fetch output; the requester re-presents the request.
                if (!stall) begin
                    if (fetch_req) begin
                        valid_d = 1'b1;
                        if (fetch_fault) begin
                            instr_d = '0;
                            fault_d = 1'b1;
                            perr_d  = 1'b0;
                        end else begin
                            instr_d = rd_data;
                            fault_d = 1'b0;
                            perr_d  = rd_perr;
                        end
                    end else begin
                        valid_d = 1'b0;
                        fault_d = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            perr_q    <= perr_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign ready       = ready_q;
`ifdef IMEM_PARITY_EN
    assign parity_err  = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q ^ rd_perr;
`endif

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync with BASE_ADDR = 0x00400000, DEPTH = 256.
module tb_instruction_memory_sync;

    localparam int          AW   = 8;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h00400000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   fetch_addr;
    logic          fetch_req;
    logic          stall;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          addr_fault;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          ready;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    int checks = 0;
    int errors = 0;

    instruction_memory_sync #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_req  (fetch_req),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .addr_fault (addr_fault),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .ready      (ready)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Release reset with a fetch pending and confirm the clear takes exactly 256 cycles.
    task automatic wait_clear(input string tag);
        int n = 0;
        bit vbad = 1'b0;
        reset      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = BASE;
        load_we    = 1'b1;
        load_addr  = 8'd5;
        load_data  = 32'hDEADBEEF;
        while (!ready && n < 400) begin
            cycle();
            n++;
            if (instr_valid !== 1'b0) vbad = 1'b1;
        end
        load_we = 1'b0;
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL %s_ready_latency got %0d cycles want 256", tag, n);
        end
        checks++;
        if (vbad || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_in_clear got 1 want 0", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_req = 1'b1; fetch_addr = BASE; stall = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) cycle();
        checks++;
        if ({ready, instr_valid, addr_fault} !== 3'b000 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b f=%b i=%h want 0 0 0 0",
                     ready, instr_valid, addr_fault, instr);
        end
        wait_clear("reset");
        cycle();
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch got i=%h v=%b f=%b want 00000000 1 0",
                     instr, instr_valid, addr_fault);
        end
    endtask

    task automatic test_load_fetch();
        fetch_req = 1'b0;
        load_we = 1'b1; load_addr = 8'd3; load_data = 32'h3c044000;
        cycle();
        load_addr = 8'd4; load_data = 32'h24840001;
        cycle();
        load_addr = 8'd255; load_data = 32'hA5A5_0FF0;
        cycle();
        load_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = BASE + 32'h0C;
        cycle();
        checks++;
        if (instr !== 32'h3c044000 || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
            errors++;
            $display("FAIL load_fetch_w3 got i=%h v=%b f=%b want 3c044000 1 0",
                     instr, instr_valid, addr_fault);
        end
        fetch_req = 1'b0;
        cycle();
        checks++;
        if (instr !== 32'h3c044000 || instr_valid !== 1'b0 || addr_fault !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got i=%h v=%b f=%b want 3c044000 0 0",
                     instr, instr_valid, addr_fault);
        end
        fetch_req = 1'b1; fetch_addr = BASE + 32'h3FC;
        cycle();
        checks++;
        if (instr !== 32'hA5A50FF0 || addr_fault !== 1'b0) begin
            errors++;
            $display("FAIL last_word got i=%h f=%b want a5a50ff0 0", instr, addr_fault);
        end
    endtask

    task automatic test_base_faults();
        logic [31:0] bad [3];
        bad[0] = 32'h003FFFFC;
        bad[1] = 32'h00400400;
        bad[2] = 32'h00400002;
        for (int k = 0; k < 3; k++) begin
            fetch_req = 1'b1; fetch_addr = BASE + 32'h0C;
            cycle();
            fetch_addr = bad[k];
            cycle();
            checks++;
            if (instr !== 32'h0 || addr_fault !== 1'b1 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL fault_%h got i=%h v=%b f=%b want 00000000 1 1",
                         bad[k], instr, instr_valid, addr_fault);
            end
        end
        // Fault flag also holds under stall, then clears on an idle cycle.
        stall = 1'b1; fetch_addr = BASE + 32'h0C;
        cycle();
        checks++;
        if (addr_fault !== 1'b1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_stall_hold got v=%b f=%b want 1 1", instr_valid, addr_fault);
        end
        stall = 1'b0; fetch_req = 1'b0;
        cycle();
        checks++;
        if (addr_fault !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got v=%b f=%b want 0 0", instr_valid, addr_fault);
        end
    endtask

    task automatic test_stall();
        bit held = 1'b1;
        fetch_req = 1'b1; fetch_addr = BASE + 32'h0C;
        cycle();
        stall = 1'b1; fetch_addr = BASE + 32'h10;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (instr !== 32'h3c044000 || instr_valid !== 1'b1) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL stall_hold got i=%h v=%b want 3c044000 1", instr, instr_valid);
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (instr !== 32'h24840001 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got i=%h v=%b want 24840001 1", instr, instr_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h3c044000;
        exp[1] = 32'h24840001;
        exp[2] = 32'h08100003;
        load_we = 1'b1; load_addr = 8'd5; load_data = 32'h08100003;
        fetch_req = 1'b1; fetch_addr = BASE + 32'h14;
        cycle();
        load_we = 1'b0;
        checks++;
        if (instr !== 32'h08100003 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL write_first got i=%h v=%b want 08100003 1", instr, instr_valid);
        end
        // Load accepted during a stall, then read back.
        stall = 1'b1; load_we = 1'b1; load_addr = 8'd6; load_data = 32'h00C0FFEE;
        cycle();
        stall = 1'b0; load_we = 1'b0; fetch_addr = BASE + 32'h18;
        cycle();
        checks++;
        if (instr !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL load_in_stall got i=%h want 00c0ffee", instr);
        end
        for (int k = 0; k < 3; k++) begin
            fetch_addr = BASE + 32'h0C + 32'(k * 4);
            cycle();
            checks++;
            if (instr !== exp[k] || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d got i=%h v=%b want %h 1", k, instr, instr_valid, exp[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b0;
        cycle();
        checks++;
        if (ready !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b v=%b i=%h want 0 0 0", ready, instr_valid, instr);
        end
        wait_clear("mid");
        fetch_addr = BASE + 32'h14;
        cycle();
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
            errors++;
            $display("FAIL recleared_w5 got i=%h v=%b f=%b want 00000000 1 0",
                     instr, instr_valid, addr_fault);
        end
        fetch_addr = BASE + 32'h0C;
        cycle();
        checks++;
        if (instr !== 32'h0) begin
            errors++;
            $display("FAIL recleared_w3 got i=%h want 00000000", instr);
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        fetch_req = 1'b0;
        load_we = 1'b1; load_addr = 8'd7; load_data = 32'h00000007;
        cycle();
        load_addr = 8'd8; load_data = 32'h00000003;
        cycle();
        load_we = 1'b0;
        force dut.par_mem[7] = 1'b0;
        fetch_req = 1'b1; fetch_addr = BASE + 32'h1C;
        cycle();
        checks++;
        if (parity_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_flip got %b want 1", parity_err);
        end
        release dut.par_mem[7];
        fetch_addr = BASE + 32'h20;
        cycle();
        checks++;
        if (parity_err !== 1'b0 || instr !== 32'h00000003) begin
            errors++;
            $display("FAIL parity_clean got pe=%b i=%h want 0 00000003", parity_err, instr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_fetch();
        test_base_faults();
        test_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
